stage4_instruction_queue: RTL

- Decoupling FIFO between the decode and execute stages of the 4-stage pipeline.
- Implements the queue side of the hazard-unit handshake: consumes flush_queue and stall_queue, produces is_queue_full.
- Decode enqueues decoded instruction bundles plus PC. Execute dequeues from a registered head entry.

---
 rtl/stage4_queue_pkg.sv | 18 +
 rtl/stage4_queue_storage.sv | 32 +++
 rtl/stage4_instruction_queue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/stage4_queue_pkg.sv
// Shared types for the decode->execute instruction queue.
package stage4_queue_pkg;

    localparam int unsigned QUEUE_DEPTH_DEFAULT = 4;
    localparam int unsigned DATA_W_DEFAULT      = 128;
    localparam int unsigned PC_W_DEFAULT        = 32;

    typedef logic [PC_W_DEFAULT-1:0] word_t;

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0] bundle;
        word_t                     pc;
    } queue_entry_t;

    typedef logic [$clog2(QUEUE_DEPTH_DEFAULT)-1:0] ptr_t;
    typedef logic [$clog2(QUEUE_DEPTH_DEFAULT):0]   cnt_t;

endpackage

// File: rtl/stage4_queue_storage.sv
// Entry register array: one write port, one asynchronous read port, synchronous clear on reset.
module stage4_queue_storage
    import stage4_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = QUEUE_DEPTH_DEFAULT,
    parameter type         entry_t = queue_entry_t
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  entry_t                   wentry_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output entry_t                   rentry_o
);

    entry_t mem_q [DEPTH];

    // Cleared on reset so the head never reads X while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wentry_i;
        end
    end

    assign rentry_o = mem_q[raddr_i];

endmodule

// File: rtl/stage4_instruction_queue.sv
// Decode->execute decoupling FIFO with hazard-unit flush/stall handshake.
// Optional STAGE4_QUEUE_BYPASS_EN: empty-queue enqueue passes straight through to a same-cycle dequeue.
module stage4_instruction_queue
    import stage4_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = QUEUE_DEPTH_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned PC_W   = PC_W_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   queue_wen,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [PC_W-1:0]        pc_in,
    input  logic                   deq,
    input  logic                   stall_queue,
    input  logic                   flush_queue,
    output logic                   is_queue_full,
    output logic                   empty,
    output logic                   valid_out,
    output logic [DATA_W-1:0]      rdata,
    output logic [PC_W-1:0]        pc_out,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow_err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [DATA_W-1:0] bundle;
        logic [PC_W-1:0]   pc;
    } entry_t;

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    logic   full_w, empty_w;
    logic   deq_eff, enq_eff, bypass, wr_en;
    entry_t head_entry, wentry;

    assign full_w  = (cnt_q == CntW'(DEPTH));
    assign empty_w = (cnt_q == '0);
    assign deq_eff = deq & ~empty_w & ~stall_queue;
    assign enq_eff = queue_wen & ~flush_queue & (~full_w | deq_eff);

`ifdef STAGE4_QUEUE_BYPASS_EN
    assign bypass = empty_w & enq_eff & deq & ~stall_queue;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry is consumed in flight and never occupies a slot.
    assign wr_en = enq_eff & ~bypass;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q | (queue_wen & full_w & ~deq_eff & ~flush_queue);
        if (flush_queue) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (deq_eff) begin
                head_d = head_q + PtrW'(1);
            end
            if (wr_en) begin
                tail_d = tail_q + PtrW'(1);
            end
            if (wr_en && !deq_eff) begin
                cnt_d = cnt_q + CntW'(1);
            end else if (deq_eff && !wr_en) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign wentry.bundle = wdata;
    assign wentry.pc     = pc_in;

    stage4_queue_storage #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_storage (
        .clk_i    (CLK),
        .rst_i    (RST),
        .we_i     (wr_en),
        .waddr_i  (tail_q),
        .wentry_i (wentry),
        .raddr_i  (head_q),
        .rentry_o (head_entry)
    );

    assign is_queue_full = full_w;
    assign empty         = empty_w;
    assign count         = cnt_q;
    assign overflow_err  = ovf_q;
    assign valid_out     = ~empty_w | bypass;
    assign rdata         = bypass ? wdata : head_entry.bundle;
    assign pc_out        = bypass ? pc_in : head_entry.pc;

endmodule
